// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and parity helper.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_PARITY = 3'd3;
   localparam rx_state_t ST_STOP   = 3'd4;

   // Parity bit that makes the frame even (even=1) or odd (even=0).
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
      return even ? ^data : ~^data;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line, frame config and received-byte status.
interface uart_rx_if;

   logic                           rx;
   logic                           parity_en;
   logic                           even_parity;
   logic [uart_pkg::DATA_BITS-1:0] rx_data;
   logic                           rx_valid;
   logic                           parity_err;
   logic                           frame_err;
   logic                           rx_busy;

   modport master (
      output rx, parity_en, even_parity,
      input  rx_data, rx_valid, parity_err, frame_err, rx_busy
   );

   modport slave (
      input  rx, parity_en, even_parity,
      output rx_data, rx_valid, parity_err, frame_err, rx_busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Synchroniser chain for the asynchronous rx pin plus falling-edge detect on the result.
module uart_rx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rxs,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs_d;

   // Reset to all ones so an idle line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         rxs_d  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         rxs_d  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rxs        = sync_q[SYNC_STAGES-1];
   assign fall_pulse = rxs_d & ~rxs;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of 8N1/8E1/8O1 frames, one-cycle rx_valid with error flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int unsigned   CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   logic rxs;
   logic fall_pulse;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .rx         (bus.rx),
      .rxs        (rxs),
      .fall_pulse (fall_pulse)
   );

   rx_state_t              state;
   rx_state_t              state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shift;
   logic                   par_en_q;
   logic                   even_q;
   logic                   perr;

   logic [DATA_BITS-1:0]   rx_data_q;
   logic                   rx_valid_q;
   logic                   parity_err_q;
   logic                   frame_err_q;
   logic                   rx_busy_q;

   logic cnt_done_c;
   logic start_c;
   logic busy_set_c;
   logic data_smp_c;
   logic par_smp_c;
   logic stop_smp_c;

   // Next state and per-cycle sample strobes.
   always_comb begin
      state_nxt  = state;
      start_c    = 1'b0;
      busy_set_c = 1'b0;
      data_smp_c = 1'b0;
      par_smp_c  = 1'b0;
      stop_smp_c = 1'b0;
      cnt_done_c = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
      case (state)
         ST_IDLE: begin
            if (fall_pulse) begin
               state_nxt = ST_START;
               start_c   = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_done_c) begin
               if (!rxs) begin
                  state_nxt  = ST_DATA;
                  busy_set_c = 1'b1;
               end else begin
                  state_nxt  = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_done_c) begin
               data_smp_c = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (cnt_done_c) begin
               par_smp_c = 1'b1;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_done_c) begin
               stop_smp_c = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Cycle counter restarts at every sample point and stays cleared while idle.
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE || cnt_done_c) cnt <= '0;
      else                                       cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)             bit_cnt <= 3'd0;
      else if (data_smp_c) bit_cnt <= bit_cnt + 3'd1;
   end

   // Frame datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift        <= '0;
         par_en_q     <= 1'b0;
         even_q       <= 1'b0;
         perr         <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_busy_q    <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (start_c) begin
            par_en_q <= bus.parity_en;
            even_q   <= bus.even_parity;
            perr     <= 1'b0;
         end
         if (busy_set_c) rx_busy_q <= 1'b1;
         if (data_smp_c) shift[bit_cnt] <= rxs;
         if (par_smp_c)  perr <= (rxs != parity_bit(shift, even_q));
         if (stop_smp_c) begin
            rx_valid_q   <= 1'b1;
            rx_data_q    <= shift;
            parity_err_q <= perr & par_en_q;
            frame_err_q  <= ~rxs;
            rx_busy_q    <= 1'b0;
         end
      end
   end

   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.rx_busy    = rx_busy_q;

endmodule
